// File: rtl/acs_path_metric_if.sv
// Symbol-in / decision-out bundle for the 4-state K=3 add-compare-select stage.
// The master side feeds branch metrics; the slave side returns metrics and decisions.
interface acs_path_metric_if #(
    parameter int PM_W = 8
);
    logic            init;
    logic            bm_valid;
    logic [1:0]      bm00;
    logic [1:0]      bm01;
    logic [1:0]      bm10;
    logic [1:0]      bm11;
    logic            dec_valid;
    logic [3:0]      dec_bits;
    logic [1:0]      best_state;
    logic [PM_W-1:0] pm0;
    logic [PM_W-1:0] pm1;
    logic [PM_W-1:0] pm2;
    logic [PM_W-1:0] pm3;
    logic [15:0]     sym_count;

    modport master (
        output init, bm_valid, bm00, bm01, bm10, bm11,
        input  dec_valid, dec_bits, best_state, pm0, pm1, pm2, pm3, sym_count
    );

    modport slave (
        input  init, bm_valid, bm00, bm01, bm10, bm11,
        output dec_valid, dec_bits, best_state, pm0, pm1, pm2, pm3, sym_count
    );
endinterface

// File: rtl/acs_path_metric.sv
// Add-compare-select with saturating adds and MSB normalization for the
// rate-1/2 K=3 (7,5) Viterbi trellis; one symbol per cycle, one cycle latency.
module acs_path_metric #(
    parameter int PM_W    = 8,
    parameter int INIT_PM = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    acs_path_metric_if.slave     bus
);

    localparam logic [PM_W:0]   SAT_MAX   = {1'b0, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0] INIT_VAL  = PM_W'(INIT_PM);
    localparam logic [PM_W-1:0] ZERO_PM   = {PM_W{1'b0}};

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                                input logic [1:0]      bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
        if (sum > SAT_MAX) begin
            sat_add = SAT_MAX[PM_W-1:0];
        end else begin
            sat_add = sum[PM_W-1:0];
        end
    endfunction

    logic [PM_W-1:0] pm_q   [4];
    logic [PM_W-1:0] pm_d   [4];
    logic [PM_W-1:0] cand0_s[4];
    logic [PM_W-1:0] cand1_s[4];
    logic [PM_W-1:0] sel_s  [4];
    logic [3:0]      dec_d;
    logic [3:0]      dec_bits_q;
    logic [1:0]      best_d;
    logic [1:0]      best_q;
    logic            dec_valid_q;
    logic [15:0]     cnt_q;
    logic            all_msb_s;
    logic [PM_W-1:0] min_s;

    // Branch additions, survivor selection, normalization and argmin.
    always_comb begin
        // Candidate 0 is always the dec-0 predecessor, candidate 1 the dec-1 one.
        cand0_s[0] = sat_add(pm_q[0], bus.bm00);
        cand1_s[0] = sat_add(pm_q[1], bus.bm11);
        cand0_s[1] = sat_add(pm_q[2], bus.bm10);
        cand1_s[1] = sat_add(pm_q[3], bus.bm01);
        cand0_s[2] = sat_add(pm_q[0], bus.bm11);
        cand1_s[2] = sat_add(pm_q[1], bus.bm00);
        cand0_s[3] = sat_add(pm_q[2], bus.bm01);
        cand1_s[3] = sat_add(pm_q[3], bus.bm10);

        for (int i = 0; i < 4; i++) begin
            dec_d[i] = (cand1_s[i] < cand0_s[i]);
            sel_s[i] = dec_d[i] ? cand1_s[i] : cand0_s[i];
        end

        all_msb_s = sel_s[0][PM_W-1] & sel_s[1][PM_W-1] &
                    sel_s[2][PM_W-1] & sel_s[3][PM_W-1];

        for (int i = 0; i < 4; i++) begin
            pm_d[i] = sel_s[i];
            if (all_msb_s) begin
                pm_d[i][PM_W-1] = 1'b0;
            end else begin
                pm_d[i][PM_W-1] = sel_s[i][PM_W-1];
            end
        end

        best_d = 2'd0;
        min_s  = pm_d[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_d[i] < min_s) begin
                min_s  = pm_d[i];
                best_d = 2'(i);
            end else begin
                min_s  = min_s;
            end
        end
    end

    // State update: reset beats init beats an accepted symbol.
    always_ff @(posedge clk) begin
        if (rst || bus.init) begin
            pm_q[0]     <= ZERO_PM;
            pm_q[1]     <= INIT_VAL;
            pm_q[2]     <= INIT_VAL;
            pm_q[3]     <= INIT_VAL;
            dec_bits_q  <= 4'd0;
            best_q      <= 2'd0;
            dec_valid_q <= 1'b0;
            cnt_q       <= 16'd0;
        end else if (bus.bm_valid) begin
            for (int i = 0; i < 4; i++) begin
                pm_q[i] <= pm_d[i];
            end
            dec_bits_q  <= dec_d;
            best_q      <= best_d;
            dec_valid_q <= 1'b1;
            cnt_q       <= cnt_q + 16'd1;
        end else begin
            dec_valid_q <= 1'b0;
        end
    end

    assign bus.pm0        = pm_q[0];
    assign bus.pm1        = pm_q[1];
    assign bus.pm2        = pm_q[2];
    assign bus.pm3        = pm_q[3];
    assign bus.dec_bits   = dec_bits_q;
    assign bus.best_state = best_q;
    assign bus.dec_valid  = dec_valid_q;
    assign bus.sym_count  = cnt_q;

endmodule

// File: tb/tb_acs_path_metric.sv
// Directed-vector bench for acs_path_metric with hand-computed trellis results.
module tb_acs_path_metric;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    acs_path_metric_if #(.PM_W(8)) bus ();

    acs_path_metric #(.PM_W(8), .INIT_PM(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pm(input string tag, input int a, input int b, input int c, input int d);
        check_eq({tag, " pm0"}, 32'(bus.pm0), 32'(a));
        check_eq({tag, " pm1"}, 32'(bus.pm1), 32'(b));
        check_eq({tag, " pm2"}, 32'(bus.pm2), 32'(c));
        check_eq({tag, " pm3"}, 32'(bus.pm3), 32'(d));
    endtask

    // One clock with the given inputs, then back to idle; outputs sampled 1ns after the edge.
    task automatic apply(input logic v, input logic ini, input logic r,
                         input logic [1:0] b00, input logic [1:0] b01,
                         input logic [1:0] b10, input logic [1:0] b11);
        bus.bm_valid = v;
        bus.init     = ini;
        rst          = r;
        bus.bm00 = b00; bus.bm01 = b01; bus.bm10 = b10; bus.bm11 = b11;
        @(posedge clk);
        #1;
        bus.bm_valid = 1'b0;
        bus.init     = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_pm(tag, 0, 16, 16, 16);
        check_eq({tag, " dv"},   32'(bus.dec_valid),  32'd0);
        check_eq({tag, " dec"},  32'(bus.dec_bits),   32'd0);
        check_eq({tag, " best"}, 32'(bus.best_state), 32'd0);
        check_eq({tag, " cnt"},  32'(bus.sym_count),  32'd0);
    endtask

    initial begin
        bus.bm_valid = 1'b0;
        bus.init     = 1'b0;
        bus.bm00 = 2'd0; bus.bm01 = 2'd0; bus.bm10 = 2'd0; bus.bm11 = 2'd0;

        // Reset with a symbol present: symbol is discarded.
        apply(1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 2'd2, 2'd2);
        check_reset_state("rst");

        // Single symbol, received 00.
        apply(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd2);
        check_pm("s00", 0, 17, 2, 17);
        check_eq("s00 dec",  32'(bus.dec_bits),   32'd0);
        check_eq("s00 best", 32'(bus.best_state), 32'd0);
        check_eq("s00 dv",   32'(bus.dec_valid),  32'd1);
        check_eq("s00 cnt",  32'(bus.sym_count),  32'd1);
        apply(1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 2'd3, 2'd3);
        check_eq("s00 dv pulse", 32'(bus.dec_valid), 32'd0);
        check_pm("s00 hold", 0, 17, 2, 17);

        // Received 11, 01, 10 along path 0->2->3->3: last step picks every odd predecessor.
        apply(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        apply(1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 2'd0);
        check_pm("s11", 2, 17, 0, 17);
        check_eq("s11 dec",  32'(bus.dec_bits),   32'd0);
        check_eq("s11 best", 32'(bus.best_state), 32'd2);
        apply(1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd2, 2'd1);
        check_pm("s01", 3, 2, 3, 0);
        check_eq("s01 dec",  32'(bus.dec_bits),   32'd0);
        check_eq("s01 best", 32'(bus.best_state), 32'd3);
        apply(1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, 2'd1);
        check_pm("s10", 3, 2, 3, 0);
        check_eq("s10 dec",  32'(bus.dec_bits),   32'd15);
        check_eq("s10 best", 32'(bus.best_state), 32'd3);
        check_eq("s10 cnt",  32'(bus.sym_count),  32'd3);

        // bm_valid pattern 1,0,0,1.
        apply(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        apply(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd2);
        check_eq("tog c1 dv", 32'(bus.dec_valid), 32'd1);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 2'd2);
        check_eq("tog c2 dv", 32'(bus.dec_valid), 32'd0);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 2'd2);
        check_eq("tog c3 dv", 32'(bus.dec_valid), 32'd0);
        check_pm("tog hold", 0, 17, 2, 17);
        check_eq("tog hold cnt", 32'(bus.sym_count), 32'd1);
        apply(1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0);
        check_eq("tog c4 dv", 32'(bus.dec_valid), 32'd1);
        check_pm("tog c4", 2, 4, 0, 2);
        check_eq("tog c4 best", 32'(bus.best_state), 32'd2);
        check_eq("tog cnt",     32'(bus.sym_count),  32'd2);

        // 64 all-ones-distance symbols: linear growth, then normalization on the 64th.
        apply(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        for (int k = 1; k <= 64; k++) begin
            apply(1'b1, 1'b0, 1'b0, 2'd2, 2'd2, 2'd2, 2'd2);
            check_eq($sformatf("run%0d dec", k), 32'(bus.dec_bits), 32'd0);
            if (k == 1) check_pm("run1", 2, 18, 2, 18);
            if (k == 2) begin
                check_pm("run2", 4, 4, 4, 4);
                check_eq("run2 best tie", 32'(bus.best_state), 32'd0);
            end
            if (k == 63) check_pm("run63", 126, 126, 126, 126);
            if (k == 64) check_pm("run64 norm", 0, 0, 0, 0);
        end
        check_eq("run cnt", 32'(bus.sym_count), 32'd64);

        // init beats a concurrent symbol.
        apply(1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 2'd2);
        check_reset_state("init");
        apply(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd2);
        check_pm("post init", 0, 17, 2, 17);
        check_eq("post init cnt", 32'(bus.sym_count), 32'd1);

        // Mid-stream reset with a symbol, then restart behaviour.
        apply(1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 2'd0);
        apply(1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 2'd1, 2'd0);
        check_reset_state("mid rst");
        apply(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd2);
        check_pm("post rst", 0, 17, 2, 17);
        check_eq("post rst dec",  32'(bus.dec_bits),   32'd0);
        check_eq("post rst best", 32'(bus.best_state), 32'd0);
        check_eq("post rst dv",   32'(bus.dec_valid),  32'd1);
        check_eq("post rst cnt",  32'(bus.sym_count),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/acs_path_metric.md
ACS_PATH_METRIC -- requirements
Module: acs_path_metric

Interface
REQ-001 Parameter PM_W, default 8, path-metric width in bits; 6 or more.
REQ-002 Parameter INIT_PM, default 16, reset/init metric for states 1..3; less than 2^(PM_W-1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 init  input  1  synchronous frame restart; reloads metrics, clears counter.
REQ-006 bm_valid  input  1  branch metrics valid this cycle.
REQ-007 bm00, bm01, bm10, bm11  input  2 each  Hamming distance of the received pair to codeword 00/01/10/11 (upstream branch-metric stage).
REQ-008 dec_valid  output  1  decision outputs valid, one-cycle pulse per accepted symbol.
REQ-009 dec_bits  output  4  survivor decision per next state; bit n is the decision for state n.
REQ-010 best_state  output  2  index of the minimum new path metric.
REQ-011 pm0, pm1, pm2, pm3  output  PM_W each  registered path metrics.
REQ-012 sym_count  output  16  count of accepted symbols since reset/init.

Function
REQ-013 Trellis: K=3, generators 7/5, 4 states; state s={s1,s0}; next state ns={u,s1}.
REQ-014 Predecessors and codewords: ns0 <- s0 via 00 (dec 0), s1 via 11 (dec 1); ns1 <- s2 via 10 (dec 0), s3 via 01 (dec 1); ns2 <- s0 via 11 (dec 0), s1 via 00 (dec 1); ns3 <- s2 via 01 (dec 0), s3 via 10 (dec 1).
REQ-015 Per ns: candidate = PM(pred) + bm(codeword), computed at PM_W+1 bits, saturated to 2^PM_W-1.
REQ-016 Compare-select: the smaller candidate wins; on a tie the dec-0 predecessor wins.
REQ-017 Normalization: if all four selected metrics have MSB (bit PM_W-1) set, clear that MSB in all four before registering; otherwise register unchanged.
REQ-018 Metrics, dec_bits, best_state and dec_valid update on the edge after bm_valid=1 is sampled; latency 1 cycle; throughput 1 symbol/cycle.
REQ-019 best_state = argmin of the registered new metrics; on a tie the lowest index wins.
REQ-020 bm_valid=0: metrics, dec_bits, best_state and sym_count hold; dec_valid=0 next cycle.
REQ-021 sym_count increments by 1 per accepted symbol; wraps 0xFFFF -> 0x0000.
REQ-022 init=1: next cycle pm0=0, pm1..pm3=INIT_PM, sym_count=0, dec_valid=0, dec_bits=0, best_state=0.
REQ-023 init and bm_valid both 1: init wins; the symbol is discarded and not counted.
REQ-024 No backpressure: every bm_valid=1 cycle with init=0 and rst=0 is accepted.

Reset
REQ-025 rst=1 at an edge: pm0=0, pm1..pm3=INIT_PM, dec_bits=0, best_state=0, dec_valid=0, sym_count=0.
REQ-026 rst has priority over init and bm_valid; a symbol presented during reset is discarded.
REQ-027 The first symbol accepted after rst deasserts is processed against the reset metrics.

Verification
REQ-028 After reset, one symbol bm00=0, bm01=1, bm10=1, bm11=2 -> pm=0,17,2,17; dec_bits=0000; best_state=0; dec_valid=1 for one cycle; sym_count=1.
REQ-029 After reset, one symbol bm00=2, bm01=1, bm10=1, bm11=0 -> pm=2,17,0,17; dec_bits=0000; best_state=2.
REQ-030 After reset, 64 consecutive symbols with all bm=2 -> after symbol 2, pm=4,4,4,4; after symbol 63, all 126; after symbol 64, normalization gives 0,0,0,0; dec_bits=0000 throughout; sym_count=64.
REQ-031 bm_valid toggled 1,0,0,1 -> dec_valid pulses only after cycles 1 and 4; metrics hold between; sym_count=2.
REQ-032 Mid-stream, init=1 with bm_valid=1 -> next cycle pm=0,16,16,16; dec_valid=0; sym_count=0.
REQ-033 Mid-stream, rst=1 for 1 cycle with bm_valid=1 -> all outputs at reset values; the next symbol behaves as in REQ-028.
